// File: rtl/trap_request_gen_pkg.sv
// Shared definitions for the trap request generator: FSM states, interrupt
// cause codes and the fixed interrupt priority order.
package trap_request_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_DRAIN         = 2'd1,
    ST_ISSUE         = 2'd2,
    ST_WAIT_REDIRECT = 2'd3
  } state_e;

  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int NUM_IRQ = 6;

  // Index 0 is the highest-priority cause.
  localparam logic [NUM_IRQ-1:0][3:0] IRQ_PRIO = {
    IRQ_STI, IRQ_SSI, IRQ_SEI, IRQ_MTI, IRQ_MSI, IRQ_MEI
  };

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;

endpackage

// File: rtl/trap_request_gen_irq_priority_encoder.sv
// Combinational interrupt takeability masking and fixed-priority selection.
module irq_priority_encoder
  import trap_request_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] mip_reg,
  input  logic [DATA_WIDTH-1:0] mie_reg,
  input  logic [DATA_WIDTH-1:0] mideleg_reg,
  input  logic [1:0]            current_mode,
  input  logic                  mstatus_mie,
  input  logic                  mstatus_sie,
  output logic                  found,
  output logic [3:0]            code
);

  logic [15:0] pend;
  logic [15:0] deleg;
  logic [15:0] takeable;
  logic        m_ok;
  logic        s_ok;
  logic        unused_hi;

  assign pend  = mip_reg[15:0] & mie_reg[15:0];
  assign deleg = mideleg_reg[15:0];

  // Machine-level interrupts are masked only while already in M with MIE clear;
  // delegated ones are never taken from M.
  assign m_ok = (current_mode != MODE_M) || mstatus_mie;
  assign s_ok = (current_mode == MODE_U) ||
                ((current_mode == MODE_S) && mstatus_sie);

  assign takeable = pend & ((deleg & {16{s_ok}}) | (~deleg & {16{m_ok}}));

  assign unused_hi = ^{mip_reg[DATA_WIDTH-1:16], mie_reg[DATA_WIDTH-1:16],
                       mideleg_reg[DATA_WIDTH-1:16]};

  // Walk from lowest to highest priority so the highest takeable cause wins.
  always_comb begin
    found = 1'b0;
    code  = 4'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (takeable[IRQ_PRIO[k]]) begin
        found = 1'b1;
        code  = IRQ_PRIO[k];
      end
    end
  end

endmodule

// File: rtl/trap_request_gen.sv
// Trap request generator: arbitrates synchronous exceptions against pending
// interrupts, drains the pipeline, issues one trap pulse, then waits for redirect.
module trap_request_gen
  import trap_request_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_code,
  input  logic [DATA_WIDTH-1:0] ex_value,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_instr,
  input  logic [DATA_WIDTH-1:0] mip_reg,
  input  logic [DATA_WIDTH-1:0] mie_reg,
  input  logic [DATA_WIDTH-1:0] mideleg_reg,
  input  logic [DATA_WIDTH-1:0] irq_pc,
  input  logic                  instr_boundary,
  input  logic [1:0]            current_mode,
  input  logic                  mstatus_mie,
  input  logic                  mstatus_sie,
  output logic                  flush_req,
  input  logic                  pipe_drained,
  input  logic                  redirect_done,
  output logic                  stall_fetch,
  output logic                  exception_valid,
  output logic [3:0]            exception_code,
  output logic                  exception_interrupt,
  output logic [DATA_WIDTH-1:0] exception_value,
  output logic [DATA_WIDTH-1:0] exception_pc,
  output logic [DATA_WIDTH-1:0] exception_instr
);

  localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            code_q, code_d;
  logic                  intr_q, intr_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  logic                  irq_found;
  logic [3:0]            irq_code;

  irq_priority_encoder #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_irq_enc (
    .mip_reg      (mip_reg),
    .mie_reg      (mie_reg),
    .mideleg_reg  (mideleg_reg),
    .current_mode (current_mode),
    .mstatus_mie  (mstatus_mie),
    .mstatus_sie  (mstatus_sie),
    .found        (irq_found),
    .code         (irq_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      intr_q  <= 1'b0;
      value_q <= '0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      intr_q  <= intr_d;
      value_q <= value_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    intr_d  = intr_q;
    value_d = value_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        // A synchronous exception beats a coincident interrupt; the interrupt
        // is still pending when we come back to IDLE.
        if (ex_valid) begin
          code_d  = ex_code;
          intr_d  = 1'b0;
          value_d = ex_value;
          pc_d    = ex_pc;
          instr_d = ex_instr;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (instr_boundary && irq_found) begin
          code_d  = irq_code;
          intr_d  = 1'b1;
          value_d = '0;
          pc_d    = irq_pc;
          instr_d = '0;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_drained || (cnt_q == CNT_MAX)) begin
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_REDIRECT;
      end
      ST_WAIT_REDIRECT: begin
        if (redirect_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode from the state register alone, so reset clears them at once.
  always_comb begin
    flush_req           = (state_q == ST_DRAIN);
    stall_fetch         = (state_q != ST_IDLE);
    exception_valid     = 1'b0;
    exception_code      = '0;
    exception_interrupt = 1'b0;
    exception_value     = '0;
    exception_pc        = '0;
    exception_instr     = '0;
    if (state_q == ST_ISSUE) begin
      exception_valid     = 1'b1;
      exception_code      = code_q;
      exception_interrupt = intr_q;
      exception_value     = value_q;
      exception_pc        = pc_q;
      exception_instr     = instr_q;
    end
  end

endmodule

// File: tb/tb_trap_request_gen.sv
// Directed bench for trap_request_gen: exceptions, interrupt priority and
// masking, drain timeout, and reset during an in-flight trap.
module tb_trap_request_gen;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic [3:0]    ex_code;
  logic [DW-1:0] ex_value;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_instr;
  logic [DW-1:0] mip_reg;
  logic [DW-1:0] mie_reg;
  logic [DW-1:0] mideleg_reg;
  logic [DW-1:0] irq_pc;
  logic          instr_boundary;
  logic [1:0]    current_mode;
  logic          mstatus_mie;
  logic          mstatus_sie;
  logic          flush_req;
  logic          pipe_drained;
  logic          redirect_done;
  logic          stall_fetch;
  logic          exception_valid;
  logic [3:0]    exception_code;
  logic          exception_interrupt;
  logic [DW-1:0] exception_value;
  logic [DW-1:0] exception_pc;
  logic [DW-1:0] exception_instr;

  int checks = 0;
  int errors = 0;

  trap_request_gen #(
    .DATA_WIDTH    (DW),
    .DRAIN_TIMEOUT (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ex_valid            (ex_valid),
    .ex_code             (ex_code),
    .ex_value            (ex_value),
    .ex_pc               (ex_pc),
    .ex_instr            (ex_instr),
    .mip_reg             (mip_reg),
    .mie_reg             (mie_reg),
    .mideleg_reg         (mideleg_reg),
    .irq_pc              (irq_pc),
    .instr_boundary      (instr_boundary),
    .current_mode        (current_mode),
    .mstatus_mie         (mstatus_mie),
    .mstatus_sie         (mstatus_sie),
    .flush_req           (flush_req),
    .pipe_drained        (pipe_drained),
    .redirect_done       (redirect_done),
    .stall_fetch         (stall_fetch),
    .exception_valid     (exception_valid),
    .exception_code      (exception_code),
    .exception_interrupt (exception_interrupt),
    .exception_value     (exception_value),
    .exception_pc        (exception_pc),
    .exception_instr     (exception_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at the negedge of the WAIT_REDIRECT cycle; ends at the next IDLE negedge.
  task automatic redirect(input string tag);
    chk({tag, "_wait_stall"}, 64'(stall_fetch), 64'd1);
    chk({tag, "_wait_valid"}, 64'(exception_valid), 64'd0);
    redirect_done = 1'b1;
    tick();
    redirect_done = 1'b0;
    chk({tag, "_idle_stall"}, 64'(stall_fetch), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_code = 4'd0; ex_value = '0; ex_pc = '0; ex_instr = '0;
    mip_reg = '0; mie_reg = '0; mideleg_reg = '0; irq_pc = '0;
    instr_boundary = 1'b0; current_mode = 2'b11; mstatus_mie = 1'b0; mstatus_sie = 1'b0;
    pipe_drained = 1'b0; redirect_done = 1'b0;
    repeat (3) tick();
    chk("rst_stall", 64'(stall_fetch), 64'd0);
    chk("rst_flush", 64'(flush_req), 64'd0);
    chk("rst_valid", 64'(exception_valid), 64'd0);
    chk("rst_pc", exception_pc, 64'd0);
    rst_n = 1'b1;
    tick();

    // Synchronous exception with the pipe already drained: pulse 2 cycles later.
    ex_valid = 1'b1; ex_code = 4'd2; ex_pc = 64'h8000_0100;
    ex_value = 64'hdead_beef; ex_instr = 64'h0000_0013; pipe_drained = 1'b1;
    tick();
    ex_valid = 1'b0; ex_code = 4'd0; ex_pc = '0; ex_value = '0; ex_instr = '0;
    chk("ex_drain_flush", 64'(flush_req), 64'd1);
    chk("ex_drain_stall", 64'(stall_fetch), 64'd1);
    chk("ex_drain_valid", 64'(exception_valid), 64'd0);
    tick();
    chk("ex_valid", 64'(exception_valid), 64'd1);
    chk("ex_code", 64'(exception_code), 64'd2);
    chk("ex_intr", 64'(exception_interrupt), 64'd0);
    chk("ex_pc", exception_pc, 64'h8000_0100);
    chk("ex_value", exception_value, 64'hdead_beef);
    chk("ex_instr", exception_instr, 64'h0000_0013);
    chk("ex_flush_issue", 64'(flush_req), 64'd0);
    tick();
    chk("ex_pulse_end", 64'(exception_valid), 64'd0);
    chk("ex_pc_cleared", exception_pc, 64'd0);
    redirect("ex");

    // Machine interrupts pending but no instruction boundary: nothing happens.
    current_mode = 2'b11; mstatus_mie = 1'b1; mideleg_reg = '0;
    mip_reg = 64'h888; mie_reg = 64'h888; irq_pc = 64'h8000_0200; instr_boundary = 1'b0;
    tick();
    tick();
    chk("nobnd_stall", 64'(stall_fetch), 64'd0);
    // Boundary reached: MEI outranks MSI and MTI.
    instr_boundary = 1'b1;
    tick();
    chk("mei_flush", 64'(flush_req), 64'd1);
    mip_reg = '0;
    tick();
    chk("mei_valid", 64'(exception_valid), 64'd1);
    chk("mei_code", 64'(exception_code), 64'd11);
    chk("mei_intr", 64'(exception_interrupt), 64'd1);
    chk("mei_pc", exception_pc, 64'h8000_0200);
    chk("mei_value", exception_value, 64'd0);
    chk("mei_instr", exception_instr, 64'd0);
    tick();
    redirect("mei");

    // Delegated SEI is never taken in M; dropping to U takes it.
    mip_reg = 64'h200; mie_reg = 64'h200; mideleg_reg = 64'h200;
    tick();
    tick();
    chk("sei_m_stall", 64'(stall_fetch), 64'd0);
    chk("sei_m_flush", 64'(flush_req), 64'd0);
    current_mode = 2'b00;
    tick();
    chk("sei_u_flush", 64'(flush_req), 64'd1);
    mip_reg = '0;
    tick();
    chk("sei_code", 64'(exception_code), 64'd9);
    chk("sei_intr", 64'(exception_interrupt), 64'd1);
    tick();
    redirect("sei");

    // SSI outranks STI.
    mideleg_reg = '0; mip_reg = 64'h22; mie_reg = 64'h22;
    tick();
    chk("ssi_flush", 64'(flush_req), 64'd1);
    mip_reg = '0;
    tick();
    chk("ssi_code", 64'(exception_code), 64'd1);
    tick();
    redirect("ssi");

    // Exception and MTI together: exception first, then MTI after redirect.
    current_mode = 2'b11; mstatus_mie = 1'b1;
    mip_reg = 64'h80; mie_reg = 64'h80;
    ex_valid = 1'b1; ex_code = 4'd5; ex_pc = 64'h1000;
    tick();
    ex_valid = 1'b0;
    chk("coll_flush", 64'(flush_req), 64'd1);
    tick();
    chk("coll_ex_code", 64'(exception_code), 64'd5);
    chk("coll_ex_intr", 64'(exception_interrupt), 64'd0);
    chk("coll_ex_pc", exception_pc, 64'h1000);
    tick();
    redirect("coll_ex");
    tick();
    chk("coll_mti_flush", 64'(flush_req), 64'd1);
    mip_reg = '0;
    tick();
    chk("coll_mti_code", 64'(exception_code), 64'd7);
    chk("coll_mti_intr", 64'(exception_interrupt), 64'd1);
    chk("coll_mti_pc", exception_pc, 64'h8000_0200);
    tick();
    redirect("coll_mti");

    // Drain timeout: 16 drain cycles with pipe_drained low; mip drops meanwhile.
    pipe_drained = 1'b0; mip_reg = 64'h80;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tmo_drain%0d", k), {62'd0, flush_req, exception_valid}, 64'd2);
      if (k == 0) mip_reg = '0;
      tick();
    end
    chk("tmo_valid", 64'(exception_valid), 64'd1);
    chk("tmo_code", 64'(exception_code), 64'd7);
    chk("tmo_intr", 64'(exception_interrupt), 64'd1);
    tick();
    redirect("tmo");
    pipe_drained = 1'b1;

    // Reset asserted in WAIT_REDIRECT clears outputs without a clock edge.
    ex_valid = 1'b1; ex_code = 4'd3; ex_pc = 64'h3000;
    tick();
    ex_valid = 1'b0;
    tick();
    tick();
    chk("rstw_stall_before", 64'(stall_fetch), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_stall", 64'(stall_fetch), 64'd0);
    chk("rstw_flush", 64'(flush_req), 64'd0);
    chk("rstw_valid", 64'(exception_valid), 64'd0);
    chk("rstw_state", 64'(dut.state_q), 64'd0);
    chk("rstw_cnt", 64'(dut.cnt_q), 64'd0);
    chk("rstw_lat_pc", dut.pc_q, 64'd0);
    tick();

    // First cycle after release evaluates a request normally.
    ex_valid = 1'b1; ex_code = 4'd4; ex_pc = 64'h4000;
    rst_n = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("post_rst_flush", 64'(flush_req), 64'd1);
    tick();
    chk("post_rst_code", 64'(exception_code), 64'd4);
    chk("post_rst_pc", exception_pc, 64'h4000);
    tick();
    redirect("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
